codec_cfg_arbiter: RTL and testbench
====================================

// Module: codec_cfg_arbiter
// PURPOSE
//  Shares the single-packet WM8731 I2C register-write engine between two requesters.
//  Requester 0 is the boot/sample-rate sequencer. Requester 1 is the runtime volume/mute control.
//  Each command is one 16-bit codec word: 7-bit register address + 9-bit data.
//  The block arbitrates, issues one word at a time, retries on NACK/timeout and reports a sticky error.
//  It sits between the control logic and the I2C write engine in the audio subsystem.
// PARAMETERS
//  MAX_RETRY      3    re-issues after the first attempt before a word is declared failed
//  TIMEOUT_CYCLES 256  cycles in S_WAIT without i_xfer_done before the attempt counts as NACK
//  BACKOFF_CYCLES 16   idle cycles between a failed attempt and its re-issue
//  STARVE_LIMIT   4    consecutive req0 grants allowed while req1 is waiting
// PORTS
//  i_clk100k    in  1   100 kHz system clock
//  i_rst        in  1   reset, asynchronous, active-high
//  i_req0_valid in  1   requester 0 has a word; held until accepted
//  i_req0_word  in  16  requester 0 codec word
//  o_req0_ready out 1   requester 0 accepted when valid&ready
//  i_req1_valid in  1   requester 1 has a word; held until accepted
//  i_req1_word  in  16  requester 1 codec word
//  o_req1_ready out 1   requester 1 accepted when valid&ready
//  o_xfer_start out 1   one-cycle pulse: write engine sends o_xfer_word
//  o_xfer_word  out 16  word for the engine; stable from S_ISSUE until return to S_IDLE
//  i_xfer_done  in  1   one-cycle pulse from the engine: frame finished
//  i_xfer_ack   in  1   qualifies i_xfer_done: 1 = all bytes ACKed, 0 = NACK
//  o_cmd_done   out 1   one-cycle pulse: current word retired (success or fail)
//  o_busy       out 1   state != S_IDLE
//  o_err        out 1   sticky: a word exhausted its retries
//  o_err_word   out 16  word that failed; o_err_src = requester index of that word
//  o_err_src    out 1   requester index of the failed word
//  i_err_clr    in  1   clears o_err (o_err_word/o_err_src keep their value)
// BEHAVIOUR
//  Reset: state=S_IDLE; all outputs 0; retry, timeout, backoff and starve counters 0. Async assert, mid-operation included: o_xfer_start drops immediately and no o_cmd_done is issued.
//  Ready: o_reqN_ready is combinational = (state==S_IDLE) && (sel==N).
//  Selection (sel) in S_IDLE:
//   - req0 wins when both are valid, unless starve_cnt==STARVE_LIMIT; then req1 wins.
//   - When only one requester is valid, that requester is selected.
//  On accept (valid&&ready):
//   - latch word and source; retry_cnt=0; go to S_ISSUE.
//   - starve_cnt: +1 if req0 granted while req1 valid, else cleared; saturates.
//  S_ISSUE: o_xfer_start=1 for exactly this cycle; timeout_cnt=0; go to S_WAIT. Accept->start latency is 1 cycle.
//  S_WAIT: timeout_cnt increments each cycle.
//   - i_xfer_done && i_xfer_ack: pulse o_cmd_done; go to S_IDLE.
//   - i_xfer_done && !ack, or timeout_cnt==TIMEOUT_CYCLES-1 with no done: attempt failed.
//   - Done and timeout in the same cycle: done wins.
//  After a failed attempt:
//   - retry_cnt<MAX_RETRY: retry_cnt+1; go to S_BACKOFF.
//   - retry_cnt==MAX_RETRY: go to S_FAIL.
//  S_BACKOFF: wait exactly BACKOFF_CYCLES cycles, then go to S_ISSUE. i_xfer_done is ignored here.
//  S_FAIL (1 cycle): set o_err=1, o_err_word=latched word, o_err_src=source; pulse o_cmd_done; go to S_IDLE.
//  Error flag:
//   - o_err is set only in S_FAIL and cleared only by i_err_clr or reset.
//   - Set and clear in the same cycle: set wins.
//   - Arbitration continues while o_err=1.
//  i_xfer_done in S_IDLE, S_ISSUE or S_BACKOFF is ignored.
//  Counter widths: $clog2(N+1) bits each. No wrap: every counter is bounded by the state machine.
// TESTING
//  1. req1 word 0x0479, engine ACKs 90 cycles after start:
//     -> ready 1 cycle, o_xfer_start 1 cycle later with o_xfer_word=0x0479, o_cmd_done 1 cycle after done, o_err=0.
//  2. req0=0x1201 and req1=0x0679 valid in the same cycle:
//     -> 0x1201 issued first; 0x0679 accepted on the first S_IDLE cycle after its o_cmd_done.
//  3. Two NACKs then ACK:
//     -> 3 o_xfer_start pulses, consecutive starts >= BACKOFF_CYCLES+1 cycles apart, single o_cmd_done, o_err=0.
//  4. Four NACKs on word 0x1019 from req0:
//     -> 4 starts, o_err=1, o_err_word=0x1019, o_err_src=0; i_err_clr -> o_err=0.
//  5. Engine never asserts done:
//     -> re-issue after TIMEOUT_CYCLES+BACKOFF_CYCLES; o_err after 4 timeouts.
//     -> i_rst mid-S_WAIT returns all outputs to 0 the same cycle.
//  6. req0 always valid, req1 valid:
//     -> req1 granted after exactly STARVE_LIMIT (4) req0 grants, then req0 resumes.

Source files
------------

// File: rtl/codec_cfg_arbiter.sv
// Two-requester arbiter in front of the single-word WM8731 I2C write engine.
// Issues one 16-bit codec word at a time, retries on NACK/timeout, keeps a sticky error.
module codec_cfg_arbiter #(
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned BACKOFF_CYCLES = 16,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic        i_clk100k,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  input  logic [15:0] i_req0_word,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [15:0] i_req1_word,
  output logic        o_req1_ready,
  output logic        o_xfer_start,
  output logic [15:0] o_xfer_word,
  input  logic        i_xfer_done,
  input  logic        i_xfer_ack,
  output logic        o_cmd_done,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_err_word,
  output logic        o_err_src,
  input  logic        i_err_clr
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW = $clog2(BACKOFF_CYCLES + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BACKOFF_LAST = BW'(BACKOFF_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX   = SW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_BACKOFF,
    S_FAIL
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_word;
  logic          r_src;
  logic [RW-1:0] r_retry_cnt;
  logic [TW-1:0] r_timeout_cnt;
  logic [BW-1:0] r_backoff_cnt;
  logic [SW-1:0] r_starve_cnt;
  logic          r_cmd_done;
  logic          r_err;
  logic [15:0]   r_err_word;
  logic          r_err_src;

  logic          w_starved;
  logic          w_sel0;
  logic          w_sel1;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_attempt_fail;

  // Selection folds in valid so ready never asserts toward an idle requester.
  assign w_starved = (r_starve_cnt == STARVE_MAX);
  assign w_sel0    = i_req0_valid && !(i_req1_valid && w_starved);
  assign w_sel1    = i_req1_valid && (!i_req0_valid || w_starved);
  assign w_grant0  = (r_state == S_IDLE) && w_sel0;
  assign w_grant1  = (r_state == S_IDLE) && w_sel1;

  always_comb begin
    w_next         = r_state;
    w_attempt_fail = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant0 || w_grant1) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_xfer_done && i_xfer_ack) begin
          w_next = S_IDLE;
        end else if (i_xfer_done || (r_timeout_cnt == TIMEOUT_LAST)) begin
          w_attempt_fail = 1'b1;
          w_next         = (r_retry_cnt == RETRY_MAX) ? S_FAIL : S_BACKOFF;
        end
      end
      S_BACKOFF: begin
        if (r_backoff_cnt == BACKOFF_LAST) w_next = S_ISSUE;
      end
      S_FAIL: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk100k or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_word        <= '0;
      r_src         <= 1'b0;
      r_retry_cnt   <= '0;
      r_timeout_cnt <= '0;
      r_backoff_cnt <= '0;
      r_starve_cnt  <= '0;
      r_cmd_done    <= 1'b0;
      r_err_word    <= '0;
      r_err_src     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cmd_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_word      <= w_grant1 ? i_req1_word : i_req0_word;
            r_src       <= w_grant1;
            r_retry_cnt <= '0;
            if (w_grant0 && i_req1_valid) begin
              if (!w_starved) r_starve_cnt <= r_starve_cnt + 1'b1;
            end else begin
              r_starve_cnt <= '0;
            end
          end
        end
        S_ISSUE: begin
          r_timeout_cnt <= '0;
        end
        S_WAIT: begin
          r_timeout_cnt <= r_timeout_cnt + 1'b1;
          if (i_xfer_done && i_xfer_ack) begin
            r_cmd_done <= 1'b1;
          end else if (w_attempt_fail) begin
            r_backoff_cnt <= '0;
            if (r_retry_cnt != RETRY_MAX) r_retry_cnt <= r_retry_cnt + 1'b1;
          end
        end
        S_BACKOFF: begin
          r_backoff_cnt <= r_backoff_cnt + 1'b1;
        end
        S_FAIL: begin
          r_err_word <= r_word;
          r_err_src  <= r_src;
          r_cmd_done <= 1'b1;
        end
        default: begin
          r_cmd_done <= 1'b0;
        end
      endcase
    end
  end

  // Setting from S_FAIL takes priority over a coincident clear.
  always_ff @(posedge i_clk100k or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (r_state == S_FAIL) begin
      r_err <= 1'b1;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_xfer_start = (r_state == S_ISSUE);
  assign o_xfer_word  = r_word;
  assign o_cmd_done   = r_cmd_done;
  assign o_busy       = (r_state != S_IDLE);
  assign o_err        = r_err;
  assign o_err_word   = r_err_word;
  assign o_err_src    = r_err_src;

endmodule

// File: tb/tb_codec_cfg_arbiter.sv
// Directed-vector bench for codec_cfg_arbiter: arbitration, retry/backoff, timeout,
// sticky error, async reset and starvation limit.
`timescale 1ns/1ns
module tb_codec_cfg_arbiter;

  localparam int HALF = 5000;

  logic        i_clk100k = 1'b0;
  logic        i_rst     = 1'b1;
  logic        i_req0_valid = 1'b0;
  logic [15:0] i_req0_word  = '0;
  logic        o_req0_ready;
  logic        i_req1_valid = 1'b0;
  logic [15:0] i_req1_word  = '0;
  logic        o_req1_ready;
  logic        o_xfer_start;
  logic [15:0] o_xfer_word;
  logic        i_xfer_done = 1'b0;
  logic        i_xfer_ack  = 1'b0;
  logic        o_cmd_done;
  logic        o_busy;
  logic        o_err;
  logic [15:0] o_err_word;
  logic        o_err_src;
  logic        i_err_clr = 1'b0;

  int n_vec   = 0;
  int n_miss  = 0;
  int cyc     = 0;
  int n_start = 0;
  int n_done  = 0;

  codec_cfg_arbiter #(
    .MAX_RETRY      (3),
    .TIMEOUT_CYCLES (256),
    .BACKOFF_CYCLES (16),
    .STARVE_LIMIT   (4)
  ) dut (
    .i_clk100k    (i_clk100k),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .i_req0_word  (i_req0_word),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_word  (i_req1_word),
    .o_req1_ready (o_req1_ready),
    .o_xfer_start (o_xfer_start),
    .o_xfer_word  (o_xfer_word),
    .i_xfer_done  (i_xfer_done),
    .i_xfer_ack   (i_xfer_ack),
    .o_cmd_done   (o_cmd_done),
    .o_busy       (o_busy),
    .o_err        (o_err),
    .o_err_word   (o_err_word),
    .o_err_src    (o_err_src),
    .i_err_clr    (i_err_clr)
  );

  always #HALF i_clk100k = ~i_clk100k;

  always @(posedge i_clk100k) begin
    cyc     <= cyc + 1;
    n_start <= n_start + (o_xfer_start ? 1 : 0);
    n_done  <= n_done + (o_cmd_done ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present a word, confirm it is taken, then confirm the 1-cycle start.
  task automatic issue(input bit src, input logic [15:0] word, output int t);
    if (src) begin
      i_req1_valid = 1'b1;
      i_req1_word  = word;
    end else begin
      i_req0_valid = 1'b1;
      i_req0_word  = word;
    end
    #1;
    check("issue_ready", src ? o_req1_ready : o_req0_ready, 1);
    check("issue_other_ready", src ? o_req0_ready : o_req1_ready, 0);
    @(negedge i_clk100k);
    if (src) i_req1_valid = 1'b0;
    else     i_req0_valid = 1'b0;
    check("issue_start", o_xfer_start, 1);
    check("issue_word", o_xfer_word, word);
    t = cyc;
  endtask

  task automatic wait_start(input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge i_clk100k);
      if (o_xfer_start) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("start_seen", 0, 1);
  endtask

  task automatic pulse_done(input logic ack);
    i_xfer_done = 1'b1;
    i_xfer_ack  = ack;
    @(negedge i_clk100k);
    i_xfer_done = 1'b0;
    i_xfer_ack  = 1'b0;
  endtask

  initial begin
    int t0, t1, t2, ds, dd;
    logic [15:0] exp6 [6];
    exp6 = '{16'h0A00, 16'h0A00, 16'h0A00, 16'h0A00, 16'h0B00, 16'h0A00};

    // Reset state
    repeat (3) @(negedge i_clk100k);
    check("rst_start", o_xfer_start, 0);
    check("rst_busy", o_busy, 0);
    check("rst_word", o_xfer_word, 0);
    check("rst_err", o_err, 0);
    check("rst_done", o_cmd_done, 0);
    check("rst_ready0", o_req0_ready, 0);
    i_rst = 1'b0;
    @(negedge i_clk100k);

    // 1: single req1 word, ACK 90 cycles after start
    issue(1'b1, 16'h0479, t0);
    @(negedge i_clk100k);
    check("t1_start_once", o_xfer_start, 0);
    check("t1_busy", o_busy, 1);
    repeat (88) @(negedge i_clk100k);
    check("t1_no_early_done", o_cmd_done, 0);
    pulse_done(1'b1);
    check("t1_cmd_done", o_cmd_done, 1);
    check("t1_err", o_err, 0);
    check("t1_idle", o_busy, 0);
    @(negedge i_clk100k);
    check("t1_done_pulse", o_cmd_done, 0);

    // 2: simultaneous requests, req0 first
    i_req0_valid = 1'b1; i_req0_word = 16'h1201;
    i_req1_valid = 1'b1; i_req1_word = 16'h0679;
    #1;
    check("t2_ready0", o_req0_ready, 1);
    check("t2_ready1", o_req1_ready, 0);
    @(negedge i_clk100k);
    i_req0_valid = 1'b0;
    check("t2_start0", o_xfer_start, 1);
    check("t2_word0", o_xfer_word, 16'h1201);
    check("t2_ready1_busy", o_req1_ready, 0);
    repeat (4) @(negedge i_clk100k);
    pulse_done(1'b1);
    check("t2_done0", o_cmd_done, 1);
    check("t2_ready1_idle", o_req1_ready, 1);
    @(negedge i_clk100k);
    i_req1_valid = 1'b0;
    check("t2_start1", o_xfer_start, 1);
    check("t2_word1", o_xfer_word, 16'h0679);
    repeat (3) @(negedge i_clk100k);
    pulse_done(1'b1);
    @(negedge i_clk100k);

    // 3: NACK, NACK (plus ignored done in backoff), ACK
    ds = n_start; dd = n_done;
    issue(1'b0, 16'h0A55, t0);
    repeat (3) @(negedge i_clk100k);
    pulse_done(1'b0);
    wait_start(40, t1);
    check("t3_gap1", t1 - t0, 20);
    repeat (3) @(negedge i_clk100k);
    pulse_done(1'b0);
    repeat (3) @(negedge i_clk100k);
    pulse_done(1'b1);
    check("t3_backoff_done_ignored", o_cmd_done, 0);
    wait_start(40, t2);
    check("t3_gap2", t2 - t1, 20);
    check("t3_word", o_xfer_word, 16'h0A55);
    repeat (3) @(negedge i_clk100k);
    pulse_done(1'b1);
    check("t3_cmd_done", o_cmd_done, 1);
    check("t3_err", o_err, 0);
    @(negedge i_clk100k);
    check("t3_starts", n_start - ds, 3);
    check("t3_dones", n_done - dd, 1);

    // 4: four NACKs -> sticky error; clear collides with set, then clear alone
    ds = n_start;
    issue(1'b0, 16'h1019, t0);
    repeat (2) @(negedge i_clk100k);
    pulse_done(1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_start(40, t1);
      repeat (2) @(negedge i_clk100k);
      pulse_done(1'b0);
    end
    check("t4_fail_busy", o_busy, 1);
    check("t4_fail_err_pre", o_err, 0);
    i_err_clr = 1'b1;
    @(negedge i_clk100k);
    i_err_clr = 1'b0;
    check("t4_err_set_wins", o_err, 1);
    check("t4_cmd_done", o_cmd_done, 1);
    check("t4_err_word", o_err_word, 16'h1019);
    check("t4_err_src", o_err_src, 0);
    check("t4_starts", n_start - ds, 4);
    i_err_clr = 1'b1;
    @(negedge i_clk100k);
    i_err_clr = 1'b0;
    check("t4_err_clr", o_err, 0);
    check("t4_err_word_kept", o_err_word, 16'h1019);

    // 5: engine silent -> timeouts, error from req1
    issue(1'b1, 16'h0E00, t0);
    for (int k = 0; k < 3; k++) begin
      wait_start(300, t1);
      check("t5_reissue_gap", t1 - t0, 273);
      t0 = t1;
    end
    repeat (257) @(negedge i_clk100k);
    check("t5_fail_busy", o_busy, 1);
    check("t5_err_pre", o_err, 0);
    @(negedge i_clk100k);
    check("t5_err", o_err, 1);
    check("t5_err_src", o_err_src, 1);
    check("t5_err_word", o_err_word, 16'h0E00);
    check("t5_cmd_done", o_cmd_done, 1);

    // 5b: async reset in the middle of S_WAIT
    issue(1'b0, 16'h0123, t0);
    repeat (5) @(negedge i_clk100k);
    dd = n_done;
    #(HALF / 2);
    i_rst = 1'b1;
    #1;
    check("t5r_start", o_xfer_start, 0);
    check("t5r_busy", o_busy, 0);
    check("t5r_word", o_xfer_word, 0);
    check("t5r_err", o_err, 0);
    check("t5r_err_word", o_err_word, 0);
    check("t5r_err_src", o_err_src, 0);
    check("t5r_cmd_done", o_cmd_done, 0);
    @(negedge i_clk100k);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk100k);
    check("t5r_no_done", n_done - dd, 0);

    // 6: starvation limit
    i_req0_word = 16'h0A00; i_req1_word = 16'h0B00;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    for (int g = 0; g < 6; g++) begin
      wait_start(10, t1);
      check("t6_grant", o_xfer_word, exp6[g]);
      if (o_xfer_word == 16'h0B00) i_req1_valid = 1'b0;
      repeat (2) @(negedge i_clk100k);
      pulse_done(1'b1);
    end
    i_req0_valid = 1'b0;
    @(negedge i_clk100k);
    check("t6_idle", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #(64'd2 * HALF * 64'd20000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

endmodule
